// File: rtl/hilo_div_if.sv
// Handshake and data bundle between the EX-stage div decode and the HI/LO divide sequencer.
// The div_zero_o signal exists only when HILO_DIV_ZERO_TRAP_EN is defined.
interface hilo_div_if #(parameter int DW = 32);
  logic          start_i;
  logic          signed_i;
  logic          annul_i;
  logic [DW-1:0] opdata1_i;
  logic [DW-1:0] opdata2_i;
  logic          stall_o;
  logic          ready_o;
  logic          hilo_we_o;
  logic [DW-1:0] hi_o;
  logic [DW-1:0] lo_o;
`ifdef HILO_DIV_ZERO_TRAP_EN
  logic          div_zero_o;
`endif

  modport master (
    output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
`ifdef HILO_DIV_ZERO_TRAP_EN
    input  div_zero_o,
`endif
    input  stall_o, ready_o, hilo_we_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
`ifdef HILO_DIV_ZERO_TRAP_EN
    output div_zero_o,
`endif
    output stall_o, ready_o, hilo_we_o, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_div_ctrl.sv
// Multi-cycle restoring DIV/DIVU sequencer: stalls EX, then issues one HI(rem)/LO(quo) write.
// Optional macro HILO_DIV_ZERO_TRAP_EN flags divide-by-zero and suppresses its HI/LO write.
module hilo_div_ctrl #(
  parameter int DW = 32,
  parameter int CW = 6
) (
  input  logic      clk,
  input  logic      rst,
  hilo_div_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_BY_ZERO, S_ON, S_END} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [DW-1:0] dvs_q, dvs_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;
  logic          zero_q, zero_d;

  // Shifted partial remainder carries one extra bit so the trial subtract keeps its carry.
  logic [DW:0]   rem_sh;
  logic [DW:0]   dvs_ext;

  function automatic logic [DW-1:0] neg_f(input logic [DW-1:0] x);
    return ~x + DW'(1);
  endfunction

  function automatic logic [DW-1:0] abs_f(input logic [DW-1:0] x);
    logic signed [DW-1:0] xs;
    xs = x;
    return (xs < 0) ? neg_f(x) : x;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    zero_d        = zero_q;
    rem_sh        = {rem_q, quo_q[DW-1]};
    dvs_ext       = {1'b0, dvs_q};
    bus.stall_o   = 1'b0;
    bus.ready_o   = 1'b0;
    bus.hilo_we_o = 1'b0;
    bus.hi_o      = '0;
    bus.lo_o      = '0;
`ifdef HILO_DIV_ZERO_TRAP_EN
    bus.div_zero_o = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          bus.stall_o = 1'b1;
          neg_quo_d   = bus.signed_i & (bus.opdata1_i[DW-1] ^ bus.opdata2_i[DW-1]);
          neg_rem_d   = bus.signed_i & bus.opdata1_i[DW-1];
          quo_d       = bus.signed_i ? abs_f(bus.opdata1_i) : bus.opdata1_i;
          dvs_d       = bus.signed_i ? abs_f(bus.opdata2_i) : bus.opdata2_i;
          rem_d       = '0;
          cnt_d       = '0;
          zero_d      = (bus.opdata2_i == '0);
          state_d     = (bus.opdata2_i == '0) ? S_BY_ZERO : S_ON;
        end
      end
      S_BY_ZERO: begin
        bus.stall_o = 1'b1;
        quo_d       = '0;
        rem_d       = '0;
        state_d     = S_END;
      end
      S_ON: begin
        bus.stall_o = 1'b1;
        if (bus.annul_i) begin
          state_d = S_IDLE;
        end else begin
          if (rem_sh >= dvs_ext) begin
            rem_d = DW'(rem_sh - dvs_ext);
            quo_d = {quo_q[DW-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[DW-1:0];
            quo_d = {quo_q[DW-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DW-1)) state_d = S_END;
        end
      end
      S_END: begin
        bus.ready_o   = 1'b1;
        bus.lo_o      = neg_quo_q ? neg_f(quo_q) : quo_q;
        bus.hi_o      = neg_rem_q ? neg_f(rem_q) : rem_q;
`ifdef HILO_DIV_ZERO_TRAP_EN
        bus.div_zero_o = zero_q;
        bus.hilo_we_o  = !bus.annul_i && !zero_q;
`else
        bus.hilo_we_o  = !bus.annul_i;
`endif
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs stay quiet for the whole reset cycle, even with start_i held.
    if (rst) begin
      bus.stall_o   = 1'b0;
      bus.ready_o   = 1'b0;
      bus.hilo_we_o = 1'b0;
      bus.hi_o      = '0;
      bus.lo_o      = '0;
`ifdef HILO_DIV_ZERO_TRAP_EN
      bus.div_zero_o = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl: latency, signed/unsigned results, divide-by-zero, annul and reset.
module tb_hilo_div_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   err_cnt = 0;
  int   chk_cnt = 0;

  always #5 clk = ~clk;

  hilo_div_if #(.DW(32)) bus ();

  hilo_div_ctrl #(.DW(32), .CW(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept at the current cycle T, wait for ready_o, check latency, stall span and results.
  task automatic run_div(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi, input int exp_lat,
                         input logic exp_we, input logic exp_dz);
    int cyc;
    int stl;
    bus.start_i   = 1'b1;
    bus.signed_i  = sg;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    #1;
    cyc = 0;
    stl = bus.stall_o ? 1 : 0;
    while (cyc < 100) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        bus.opdata1_i = ~a;
        bus.opdata2_i = 32'h0;
        #1;
      end
      if (bus.ready_o) break;
      if (bus.stall_o) stl++;
    end
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " stall_cycles"}, stl, exp_lat);
    check({tag, " stall_end"}, bus.stall_o, 1'b0);
    check({tag, " lo"}, bus.lo_o, exp_lo);
    check({tag, " hi"}, bus.hi_o, exp_hi);
    check({tag, " we"}, bus.hilo_we_o, exp_we);
`ifdef HILO_DIV_ZERO_TRAP_EN
    check({tag, " div_zero"}, bus.div_zero_o, exp_dz);
`else
    check({tag, " dz_unused"}, {31'b0, exp_dz}, 32'h0);
`endif
    bus.start_i = 1'b0;
    tick();
    check({tag, " we_after"}, bus.hilo_we_o, 1'b0);
    check({tag, " ready_after"}, bus.ready_o, 1'b0);
    check({tag, " lo_after"}, bus.lo_o, 32'h0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.start_i   = 1'b1;
    bus.signed_i  = 1'b0;
    bus.annul_i   = 1'b0;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    tick();
    tick();
    check("rst stall", bus.stall_o, 1'b0);
    check("rst ready", bus.ready_o, 1'b0);
    check("rst we", bus.hilo_we_o, 1'b0);
    check("rst hi", bus.hi_o, 32'h0);
    check("rst lo", bus.lo_o, 32'h0);
    bus.start_i = 1'b0;
    rst = 1'b0;
    tick();
    check("idle stall", bus.stall_o, 1'b0);

    run_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b1, 1'b0);
    run_div("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b1, 1'b0);
    run_div("u-7_2", 1'b0, 32'hFFFF_FFF9, 32'h2, 32'h7FFF_FFFC, 32'h1, 33, 1'b1, 1'b0);
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 33, 1'b1, 1'b0);
    run_div("s7_-2", 1'b1, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1, 33, 1'b1, 1'b0);
    run_div("uffff_1", 1'b0, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h0, 33, 1'b1, 1'b0);
    run_div("u5_9", 1'b0, 32'd5, 32'd9, 32'h0, 32'd5, 33, 1'b1, 1'b0);
`ifdef HILO_DIV_ZERO_TRAP_EN
    run_div("dz", 1'b0, 32'h1234, 32'h0, 32'h0, 32'h0, 2, 1'b0, 1'b1);
`else
    run_div("dz", 1'b0, 32'h1234, 32'h0, 32'h0, 32'h0, 2, 1'b1, 1'b0);
`endif

    // Annul mid-iteration, then restart two cycles later.
    bus.start_i   = 1'b1;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    #1;
    check("ann accept_stall", bus.stall_o, 1'b1);
    repeat (10) tick();
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    #1;
    check("ann on_stall", bus.stall_o, 1'b1);
    tick();
    check("ann idle_stall", bus.stall_o, 1'b0);
    check("ann idle_ready", bus.ready_o, 1'b0);
    check("ann idle_we", bus.hilo_we_o, 1'b0);
    bus.annul_i = 1'b0;
    tick();
    check("ann quiet_we", bus.hilo_we_o, 1'b0);
    run_div("ann_restart", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b1, 1'b0);

    // Annul arriving in the END cycle blocks only the write.
    bus.start_i   = 1'b1;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    repeat (33) tick();
    bus.annul_i = 1'b1;
    #1;
    check("end_ann ready", bus.ready_o, 1'b1);
    check("end_ann we", bus.hilo_we_o, 1'b0);
    check("end_ann lo", bus.lo_o, 32'd14);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    tick();

    // Reset mid-divide with start_i held throughout.
    bus.start_i   = 1'b1;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    check("mid_rst stall", bus.stall_o, 1'b0);
    check("mid_rst ready", bus.ready_o, 1'b0);
    check("mid_rst we", bus.hilo_we_o, 1'b0);
    check("mid_rst lo", bus.lo_o, 32'h0);
    tick();
    check("mid_rst held_stall", bus.stall_o, 1'b0);
    rst = 1'b0;
    run_div("post_rst", 1'b0, 32'd5, 32'd9, 32'h0, 32'd5, 33, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/hilo_div_ctrl.md
Name: hilo_div_ctrl

Overview:
- Multi-cycle divide sequencer in the EX stage. Accepts DIV/DIVU operands and stalls the pipeline while it iterates.
- Produces a single-cycle HI/LO write request: remainder to HI, quotient to LO.
- Sits between the EX decode of div ops and the HI/LO write-back path. EX muxes hilo_we_o/hi_o/lo_o into the HI/LO write port.

Parameters:
- DW, 32, operand and result width; HI and LO are each DW bits.
- CW, 6, iteration counter width; must satisfy 2^CW > DW.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high (Rst_Enable).
- start_i  in  1  divide request; held high by EX while the div instruction occupies EX.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- annul_i  in  1  flush/cancel of the in-flight divide.
- opdata1_i  in  DW  dividend.
- opdata2_i  in  DW  divisor.
- stall_o  out  1  pipeline stall request.
- ready_o  out  1  result valid this cycle.
- hilo_we_o  out  1  HI/LO write enable pulse.
- hi_o  out  DW  remainder.
- lo_o  out  DW  quotient.

Behaviour:
- Reset: state=IDLE, counter=0, internal remainder/quotient registers=0. Outputs: stall_o=0, ready_o=0, hilo_we_o=0, hi_o=0, lo_o=0. Reset wins over every other input in any state.
- States: IDLE, BY_ZERO, ON, END.
- IDLE:
  - If start_i=1 and annul_i=0:
    - Latch the signs of both operands and signed_i.
    - Load the magnitudes: abs value if signed_i, else raw.
    - Go to BY_ZERO if opdata2_i==0, else go to ON with counter=0.
  - Otherwise stay in IDLE.
- BY_ZERO: quotient=0, remainder=0; go to END next cycle.
- ON:
  - One restoring step per cycle. Shift {rem, quo} left by 1. If shifted rem >= |divisor|, subtract and set quo LSB=1, else set LSB=0.
  - Counter increments each step. After DW steps (counter==DW-1 in the current cycle), go to END.
  - annul_i=1 in ON: go to IDLE next cycle; no write is issued.
- END (exactly one cycle):
  - ready_o=1 and hilo_we_o=1.
  - lo_o = quotient, negated if signed_i and the operand signs differ.
  - hi_o = remainder, negated if signed_i and the dividend is negative.
  - Return to IDLE.
  - annul_i=1 in END suppresses hilo_we_o; ready_o stays 1.
- stall_o (combinational) = (IDLE and start_i and !annul_i) or BY_ZERO or ON. It is 0 in END so the div instruction advances.
- hi_o/lo_o are zero outside END.
- Latency, with the accept cycle as T:
  - Normal divide: END at T+DW+1, i.e. T+33 for DW=32.
  - Divide by zero: END at T+2.
- start_i sampled high in IDLE on the cycle after END is a new request.
- Operand changes after acceptance are ignored.
- Overflow: signed 0x80000000 / -1 wraps to quotient 0x80000000, remainder 0. No exception is raised.
- Width rules:
  - Internal remainder is DW+1 bits so the trial subtract does not lose the carry.
  - Negation is two's complement modulo 2^DW.

Optional Feature:
- Macro: HILO_DIV_ZERO_TRAP_EN.
- When defined:
  - Adds output div_zero_o (1 bit), asserted together with ready_o in END for a BY_ZERO operation.
  - hilo_we_o is forced 0 for that operation, so HI/LO keep their previous values.
- When undefined:
  - No extra port.
  - Divide by zero writes HI=0, LO=0 with hilo_we_o=1.

Test Plan:
- Unsigned 100/7, start at T → stall_o 1 for T..T+32; END at T+33 with lo_o=14, hi_o=2, hilo_we_o=1 for exactly one cycle.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; signed 0x80000000 / 0xFFFFFFFF → lo_o=0x80000000, hi_o=0.
- Unsigned 0xFFFFFFFF/1 → lo_o=0xFFFFFFFF, hi_o=0; DIVU 5/9 → lo_o=0, hi_o=5.
- Divisor 0, dividend 0x1234 → END at T+2 with hi_o=lo_o=0 and hilo_we_o=1. With HILO_DIV_ZERO_TRAP_EN defined: div_zero_o=1 and hilo_we_o=0.
- Start 100/7, assert annul_i at T+10 → IDLE at T+11, stall_o=0 from T+11, no hilo_we_o pulse. A new start at T+12 completes normally at T+45.
- rst=1 at T+20 mid-divide → next cycle all outputs 0 and state IDLE. start_i held through reset has no effect until rst=0.
